msk_share_encoder: RTL and testbench

Converts unmasked W-bit words into d-share Boolean sharings for the masked datapath. It is the producing end of the sharing interface consumed by the masked gadgets (`MSKand_*`, `clyde_MSK_*`). It pulls fresh randomness from the PRNG over a valid/ready port and emits bit-sliced sharings over a valid/ready port. Plaintext is never stored in a register.

---
 rtl/msk_pkg.sv | 25 ++
 rtl/msk_rnd_gather.sv | 72 +++++++
 rtl/msk_share_encoder.sv | 111 +++++++++++
 tb/tb_msk_share_encoder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_pkg.sv
// Shared definitions for the masked datapath: randomness sizing, bit-sliced
// share indexing and the share-encoder FSM state encoding.
package msk_pkg;

    typedef enum logic [1:0] {
        StFill = 2'd0,
        StLoad = 2'd1,
        StOut  = 2'd2
    } msk_enc_state_e;

    // Number of RW-bit beats needed to cover the (d-1)*W fresh random bits of one word.
    function automatic int unsigned n_rnd_beats(input int unsigned d,
                                                input int unsigned w,
                                                input int unsigned rw);
        return ((d - 1) * w + rw - 1) / rw;
    endfunction

    // Position of share k of bit i in a bit-sliced d-share vector.
    function automatic int unsigned sh_idx(input int unsigned i,
                                           input int unsigned k,
                                           input int unsigned d);
        return d * i + k;
    endfunction

endpackage

// File: rtl/msk_rnd_gather.sv
// Collects NB beats of PRNG output into an (d-1)*W-bit buffer, one beat per
// accepted handshake, and pulses last_o on the beat that completes the buffer.
module msk_rnd_gather
    import msk_pkg::*;
#(
    parameter int unsigned d  = 2,
    parameter int unsigned W  = 32,
    parameter int unsigned RW = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic [RW-1:0]         rnd_i,
    input  logic                  rnd_valid_i,
    output logic                  rnd_ready_o,
    output logic                  last_o,
    output logic [(d-1)*W-1:0]    buf_o
);

    localparam int unsigned NR = (d - 1) * W;
    localparam int unsigned NB = n_rnd_beats(d, W, RW);
    localparam int unsigned CW = $clog2(NB + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic [NR-1:0] buf_q, buf_d;
    logic          fire;

    assign rnd_ready_o = en_i & ~full_q;
    assign fire        = rnd_ready_o & rnd_valid_i;
    assign last_o      = fire && (cnt_q == CW'(NB - 1));
    assign buf_o       = buf_q;

    always_comb begin
        cnt_d  = cnt_q;
        full_d = full_q;
        buf_d  = buf_q;
        if (clear_i) begin
            // Buffer is spent once a word has been shared with it.
            cnt_d  = '0;
            full_d = 1'b0;
            buf_d  = '0;
        end else if (fire) begin
            // Bits of the last beat beyond NR have no destination and are dropped.
            for (int j = 0; j < int'(NR); j++) begin
                if (cnt_q == CW'(j / int'(RW))) begin
                    buf_d[j] = rnd_i[j % int'(RW)];
                end
            end
            if (last_o) begin
                cnt_d  = '0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            buf_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: rtl/msk_share_encoder.sv
// Turns unmasked W-bit words into bit-sliced d-share Boolean sharings using
// fresh PRNG randomness; plaintext only ever feeds the share-0 XOR tree.
module msk_share_encoder
    import msk_pkg::*;
#(
    parameter int unsigned d  = 2,
    parameter int unsigned W  = 32,
    parameter int unsigned RW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RW-1:0]    rnd_in,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    output logic [d*W-1:0]   sh_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned NR = (d - 1) * W;

    msk_enc_state_e state_q, state_d;
    logic           run_q;
    logic [d*W-1:0] sh_q, sh_d;
    logic [NR-1:0]  rnd_buf;
    logic           gather_en;
    logic           accept;
    logic           last_beat;

    msk_rnd_gather #(
        .d  (d),
        .W  (W),
        .RW (RW)
    ) u_gather (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (gather_en),
        .clear_i     (accept),
        .rnd_i       (rnd_in),
        .rnd_valid_i (rnd_valid),
        .rnd_ready_o (rnd_ready),
        .last_o      (last_beat),
        .buf_o       (rnd_buf)
    );

    // Handshake outputs come from state flops only; run_q keeps rnd_ready low
    // during the reset cycle itself.
    always_comb begin
        state_d   = state_q;
        gather_en = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StFill: begin
                gather_en = run_q;
                if (last_beat) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    assign accept = in_ready & in_valid;

    always_comb begin
        logic acc;
        sh_d = '0;
        acc  = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            acc = data_in[i];
            for (int unsigned k = 1; k < d; k++) begin
                sh_d[sh_idx(i, k, d)] = rnd_buf[(k - 1) * W + i];
                acc = acc ^ rnd_buf[(k - 1) * W + i];
            end
            sh_d[sh_idx(i, 0, d)] = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFill;
            run_q   <= 1'b0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (accept) begin
                sh_q <= sh_d;
            end
        end
    end

    assign sh_out = sh_q;

endmodule

// File: tb/tb_msk_share_encoder.sv
// Directed bench for msk_share_encoder in three configurations, with a
// per-instance queue of expected sharings checked at each output handshake.
module tb_msk_share_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    // d=2, W=8, RW=8
    logic [7:0]  a_data, a_rnd;
    logic        a_iv, a_ir, a_rv, a_rr, a_ov, a_or;
    logic [15:0] a_sh;
    // d=3, W=32, RW=32
    logic [31:0] b_data, b_rnd;
    logic        b_iv, b_ir, b_rv, b_rr, b_ov, b_or;
    logic [95:0] b_sh;
    // d=3, W=8, RW=32
    logic [7:0]  c_data;
    logic [31:0] c_rnd;
    logic        c_iv, c_ir, c_rv, c_rr, c_ov, c_or;
    logic [23:0] c_sh;

    logic [127:0] a_q[$];
    logic [127:0] b_q[$];

    msk_share_encoder #(.d(2), .W(8), .RW(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_data), .in_valid(a_iv), .in_ready(a_ir),
        .rnd_in(a_rnd), .rnd_valid(a_rv), .rnd_ready(a_rr), .sh_out(a_sh),
        .out_valid(a_ov), .out_ready(a_or)
    );

    msk_share_encoder #(.d(3), .W(32), .RW(32)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_data), .in_valid(b_iv), .in_ready(b_ir),
        .rnd_in(b_rnd), .rnd_valid(b_rv), .rnd_ready(b_rr), .sh_out(b_sh),
        .out_valid(b_ov), .out_ready(b_or)
    );

    msk_share_encoder #(.d(3), .W(8), .RW(32)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .data_in(c_data), .in_valid(c_iv), .in_ready(c_ir),
        .rnd_in(c_rnd), .rnd_valid(c_rv), .rnd_ready(c_rr), .sh_out(c_sh),
        .out_valid(c_ov), .out_ready(c_or)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference sharing: share k>0 of bit i is random bit (k-1)*w+i, share 0 closes the XOR.
    function automatic logic [127:0] model(input int dd, input int w,
                                           input logic [127:0] rbuf, input logic [31:0] data);
        logic [127:0] r;
        logic         s0;
        r = '0;
        for (int i = 0; i < w; i++) begin
            s0 = data[i];
            for (int k = 1; k < dd; k++) begin
                r[dd * i + k] = rbuf[(k - 1) * w + i];
                s0 = s0 ^ rbuf[(k - 1) * w + i];
            end
            r[dd * i] = s0;
        end
        return r;
    endfunction

    function automatic logic [31:0] unslice(input logic [127:0] sh, input int dd, input int w,
                                            input int k);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = sh[dd * i + k];
        return r;
    endfunction

    task automatic a_beat(input logic [7:0] v);
        int n;
        n = 0;
        a_rnd = v;
        a_rv  = 1'b1;
        while (a_rr !== 1'b1 && n < 50) begin tick(); n++; end
        chk("a_rnd_ready", 128'(a_rr), 128'(1));
        tick();
        a_rv  = 1'b0;
        a_rnd = 8'($urandom);
    endtask

    task automatic a_word(input logic [7:0] v, input logic [7:0] rbuf);
        int n;
        n = 0;
        a_data = v;
        a_iv   = 1'b1;
        while (a_ir !== 1'b1 && n < 50) begin tick(); n++; end
        chk("a_in_ready", 128'(a_ir), 128'(1));
        chk("a_ov_before_data", 128'(a_ov), 128'(0));
        a_q.push_back(model(2, 8, 128'(rbuf), 32'(v)));
        tick();
        a_iv   = 1'b0;
        a_data = 8'($urandom);
        chk("a_ov_latency", 128'(a_ov), 128'(1));
    endtask

    task automatic a_take();
        int n;
        n = 0;
        a_or = 1'b1;
        while (a_ov !== 1'b1 && n < 50) begin tick(); n++; end
        chk("a_out_valid", 128'(a_ov), 128'(1));
        chk("a_sh_out", 128'(a_sh), a_q.pop_front());
        tick();
        a_or = 1'b0;
        chk("a_rnd_ready_after_out", 128'(a_rr), 128'(1));
    endtask

    task automatic b_beat(input logic [31:0] v);
        int n;
        n = 0;
        b_rnd = v;
        b_rv  = 1'b1;
        while (b_rr !== 1'b1 && n < 50) begin tick(); n++; end
        chk("b_rnd_ready", 128'(b_rr), 128'(1));
        tick();
        b_rv  = 1'b0;
        b_rnd = $urandom;
    endtask

    task automatic b_word(input logic [31:0] v, input logic [63:0] rbuf);
        int n;
        n = 0;
        b_data = v;
        b_iv   = 1'b1;
        while (b_ir !== 1'b1 && n < 50) begin tick(); n++; end
        chk("b_in_ready", 128'(b_ir), 128'(1));
        b_q.push_back(model(3, 32, 128'(rbuf), v));
        tick();
        b_iv   = 1'b0;
        b_data = $urandom;
        chk("b_ov_latency", 128'(b_ov), 128'(1));
    endtask

    task automatic b_take();
        int n;
        n = 0;
        b_or = 1'b1;
        while (b_ov !== 1'b1 && n < 50) begin tick(); n++; end
        chk("b_out_valid", 128'(b_ov), 128'(1));
        chk("b_sh_out", 128'(b_sh), b_q.pop_front());
        tick();
        b_or = 1'b0;
        chk("b_rnd_ready_after_out", 128'(b_rr), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0]  held;
        logic [7:0]   r8, v8;
        logic [127:0] exp_c;
        int           n;

        rst_n  = 1'b0;
        a_data = '0; a_rnd = '0; a_iv = 1'b0; a_rv = 1'b0; a_or = 1'b0;
        b_data = '0; b_rnd = '0; b_iv = 1'b0; b_rv = 1'b0; b_or = 1'b0;
        c_data = '0; c_rnd = '0; c_iv = 1'b0; c_rv = 1'b0; c_or = 1'b0;
        tick();
        tick();
        chk("rst_a_rnd_ready", 128'(a_rr), 128'(0));
        chk("rst_a_in_ready", 128'(a_ir), 128'(0));
        chk("rst_a_out_valid", 128'(a_ov), 128'(0));
        chk("rst_a_sh_out", 128'(a_sh), 128'(0));
        chk("rst_b_rnd_ready", 128'(b_rr), 128'(0));
        chk("rst_b_sh_out", 128'(b_sh), 128'(0));
        rst_n = 1'b1;
        tick();
        chk("a_rnd_ready_after_release", 128'(a_rr), 128'(1));

        // d=2: beat 0xA5, data 0x3C -> share1 0xA5, share0 0x99
        a_beat(8'hA5);
        chk("a_in_ready_lat", 128'(a_ir), 128'(1));
        a_word(8'h3C, 8'hA5);
        chk("a_sliced_const", 128'(a_sh), 128'(16'hC963));
        chk("a_share1", 128'(unslice(128'(a_sh), 2, 8, 1)), 128'(8'hA5));
        chk("a_share0", 128'(unslice(128'(a_sh), 2, 8, 0)), 128'(8'h99));
        a_take();

        for (int i = 0; i < 4; i++) begin
            r8 = 8'($urandom);
            v8 = 8'($urandom);
            a_beat(r8);
            a_word(v8, r8);
            a_take();
        end

        // Backpressure: 10 stalled cycles with a different beat offered throughout
        a_beat(8'h3D);
        a_word(8'h77, 8'h3D);
        held  = a_sh;
        a_rnd = 8'hFF;
        a_rv  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_sh_stable", 128'(a_sh), 128'(held));
            chk("bp_rnd_ready", 128'(a_rr), 128'(0));
            chk("bp_out_valid", 128'(a_ov), 128'(1));
        end
        a_take();
        a_beat(8'h5A);
        a_word(8'h00, 8'h5A);
        chk("bp_fresh_share1", 128'(unslice(128'(a_sh), 2, 8, 1)), 128'(8'h5A));
        a_take();

        // d=3, W=32: two beats become shares 1 and 2
        b_beat(32'h01234567);
        chk("b_in_ready_one_beat", 128'(b_ir), 128'(0));
        b_beat(32'h89ABCDEF);
        chk("b_in_ready_lat", 128'(b_ir), 128'(1));
        b_word(32'hDEADBEEF, {32'h89ABCDEF, 32'h01234567});
        chk("b_share1", 128'(unslice(128'(b_sh), 3, 32, 1)), 128'(32'h01234567));
        chk("b_share2", 128'(unslice(128'(b_sh), 3, 32, 2)), 128'(32'h89ABCDEF));
        chk("b_share0", 128'(unslice(128'(b_sh), 3, 32, 0)),
            128'(32'hDEADBEEF ^ 32'h01234567 ^ 32'h89ABCDEF));
        chk("b_recombined", 128'(unslice(128'(b_sh), 3, 32, 0) ^ unslice(128'(b_sh), 3, 32, 1)
                                 ^ unslice(128'(b_sh), 3, 32, 2)), 128'(32'hDEADBEEF));
        b_take();

        // Reset after 1 of 2 beats: the stale beat must not count
        b_beat(32'h11111111);
        rst_n = 1'b0;
        tick();
        chk("b_mid_rst_rnd_ready", 128'(b_rr), 128'(0));
        chk("b_mid_rst_out_valid", 128'(b_ov), 128'(0));
        rst_n = 1'b1;
        tick();
        b_beat(32'h22222222);
        chk("b_post_rst_need_two", 128'(b_ir), 128'(0));
        chk("b_post_rst_no_out", 128'(b_ov), 128'(0));
        b_beat(32'h33333333);
        chk("b_post_rst_in_ready", 128'(b_ir), 128'(1));
        b_word(32'hCAFEF00D, {32'h33333333, 32'h22222222});
        b_take();

        // Reset while a sharing is pending in OUT
        a_beat(8'h66);
        a_word(8'h81, 8'h66);
        rst_n = 1'b0;
        tick();
        chk("a_out_rst_out_valid", 128'(a_ov), 128'(0));
        chk("a_out_rst_sh_out", 128'(a_sh), 128'(0));
        chk("a_out_rst_in_ready", 128'(a_ir), 128'(0));
        void'(a_q.pop_back());
        rst_n = 1'b1;
        tick();
        chk("a_out_rst_no_replay", 128'(a_ov), 128'(0));
        a_beat(8'h12);
        a_word(8'h34, 8'h12);
        a_take();

        // d=3, W=8, RW=32: one beat, only its low 16 bits are used
        n = 0;
        c_rnd = 32'hFFFF00AA;
        c_rv  = 1'b1;
        while (c_rr !== 1'b1 && n < 50) begin tick(); n++; end
        chk("c_rnd_ready", 128'(c_rr), 128'(1));
        tick();
        c_rv  = 1'b0;
        chk("c_single_beat", 128'(c_ir), 128'(1));
        c_data = 8'h5C;
        c_iv   = 1'b1;
        tick();
        c_iv   = 1'b0;
        chk("c_ov_latency", 128'(c_ov), 128'(1));
        exp_c = model(3, 8, 128'(16'h00AA), 32'h5C);
        chk("c_sh_out", 128'(c_sh), exp_c);
        chk("c_share1", 128'(unslice(128'(c_sh), 3, 8, 1)), 128'(8'hAA));
        chk("c_share2", 128'(unslice(128'(c_sh), 3, 8, 2)), 128'(8'h00));
        chk("c_share0", 128'(unslice(128'(c_sh), 3, 8, 0)), 128'(8'h5C ^ 8'hAA));
        c_or = 1'b1;
        tick();
        c_or = 1'b0;
        chk("c_rnd_ready_after_out", 128'(c_rr), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
